// File: rtl/divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
//   div_state_t        : controller states (IDLE, CALC, FINISH)
//   DIV_WIDTH_DEFAULT  : default operand / quotient / remainder width
package divider_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FINISH
  } div_state_t;

  localparam int DIV_WIDTH_DEFAULT = 4;

endpackage

// File: rtl/divider_4bit_seq_if.sv
// Request/result bundle for the sequential divider.
//   master : drives start, a (dividend), b (divisor); receives results
//   slave  : the divider; drives out (quotient), rem (remainder),
//            V (divide-by-zero), Z (quotient zero), busy, done
interface divider_4bit_seq_if
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] rem;
  logic             V;
  logic             Z;
  logic             busy;
  logic             done;

  modport master (
    output start, a, b,
    input  out, rem, V, Z, busy, done
  );

  modport slave (
    input  start, a, b,
    output out, rem, V, Z, busy, done
  );

endinterface

// File: rtl/div_restoring_step.sv
// One restoring-division iteration (purely combinational).
//   r_in  : partial remainder, WIDTH+1 bits
//   q_in  : dividend/quotient shift register; its MSB is the next dividend bit
//   b     : divisor
//   r_out : partial remainder after shift and conditional subtract
//   q_out : shift register after shift, with the new quotient bit in bit 0
module div_restoring_step
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic [WIDTH:0]   r_in,
  input  logic [WIDTH-1:0] q_in,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH:0]   r_out,
  output logic [WIDTH-1:0] q_out
);

  logic [WIDTH:0]   r_sh;
  logic [WIDTH-1:0] q_sh;
  // The remainder MSB is always zero after a restoring step, so it is shifted
  // out and never reaches the comparison.
  logic             unused_r_msb;

  assign unused_r_msb = r_in[WIDTH];

  // NOTE: every output gets a default before the conditional update, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    r_sh  = {r_in[WIDTH-1:0], q_in[WIDTH-1]};
    q_sh  = q_in << 1;
    r_out = r_sh;
    q_out = q_sh;
    if (r_sh >= {1'b0, b}) begin
      r_out = r_sh - {1'b0, b};
      q_out = q_sh | WIDTH'(1);
    end
  end

endmodule

// File: rtl/divider_4bit_seq.sv
// Iterative restoring unsigned divider: quotient and remainder of a/b in
// WIDTH cycles, one quotient bit per cycle.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : slave side of divider_4bit_seq_if
//                start/a/b sampled in IDLE; out/rem/V/Z registered and held
//                until the next FINISH; busy while not IDLE; done in FINISH.
// Divide-by-zero skips CALC and reports out=all ones, rem=a, V=1, Z=0.
module divider_4bit_seq
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  divider_4bit_seq_if.slave   bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  div_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [WIDTH:0]   r_q,     r_d;
  logic [WIDTH-1:0] q_q,     q_d;
  logic [WIDTH-1:0] b_q,     b_d;
  logic [WIDTH-1:0] out_q,   out_d;
  logic [WIDTH-1:0] rem_q,   rem_d;
  logic             v_q,     v_d;
  logic             z_q,     z_d;

  logic [WIDTH:0]   r_step;
  logic [WIDTH-1:0] q_step;

  div_restoring_step #(.WIDTH(WIDTH)) u_step (
    .r_in  (r_q),
    .q_in  (q_q),
    .b     (b_q),
    .r_out (r_step),
    .q_out (q_step)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    q_d     = q_q;
    b_d     = b_q;
    out_d   = out_q;
    rem_d   = rem_q;
    v_d     = v_q;
    z_d     = z_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          // The shift register starts out holding the dividend; its bits move
          // into the remainder while quotient bits fill in from the bottom.
          b_d   = bus.b;
          r_d   = '0;
          q_d   = bus.a;
          cnt_d = '0;
          if (bus.b == '0) begin
            state_d = FINISH;
            out_d   = '1;
            rem_d   = bus.a;
            v_d     = 1'b1;
            z_d     = 1'b0;
          end else begin
            state_d = CALC;
          end
        end
      end

      CALC: begin
        r_d   = r_step;
        q_d   = q_step;
        cnt_d = cnt_q + CNT_W'(1);
        // Results are captured from the final step so they are already valid
        // in the cycle done is raised.
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = FINISH;
          out_d   = q_step;
          rem_d   = r_step[WIDTH-1:0];
          v_d     = 1'b0;
          z_d     = (q_step == '0);
        end
      end

      FINISH:  state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order. All state, datapath
  // and result registers are reset; there is no memory array to leave uncleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      q_q     <= '0;
      b_q     <= '0;
      out_q   <= '0;
      rem_q   <= '0;
      v_q     <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      q_q     <= q_d;
      b_q     <= b_d;
      out_q   <= out_d;
      rem_q   <= rem_d;
      v_q     <= v_d;
      z_q     <= z_d;
    end
  end

  assign bus.out  = out_q;
  assign bus.rem  = rem_q;
  assign bus.V    = v_q;
  assign bus.Z    = z_q;
  assign bus.busy = (state_q != IDLE);
  assign bus.done = (state_q == FINISH);

endmodule

// File: tb/tb_divider_4bit_seq.sv
// Self-checking bench for divider_4bit_seq: directed scenarios followed by
// randomized operations compared against an arithmetic reference model.
module tb_divider_4bit_seq;
  import divider_pkg::*;

  localparam int W    = DIV_WIDTH_DEFAULT;
  localparam int MASK = (1 << W) - 1;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  divider_4bit_seq_if #(.WIDTH(W)) bus ();

  divider_4bit_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Last reported result, used to check that outputs hold between operations.
  int prev_out = 0;
  int prev_rem = 0;
  int prev_v   = 0;
  int prev_z   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; sample and drive 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer division with the divide-by-zero convention.
  task automatic ref_div(input int a, input int b,
                         output int q, output int r, output int v, output int z);
    if (b == 0) begin
      q = MASK; r = a; v = 1; z = 0;
    end else begin
      q = a / b; r = a % b; v = 0; z = (q == 0) ? 1 : 0;
    end
  endtask

  task automatic check_held(input string tag);
    check({tag, ".out_hold"}, 32'(bus.out), prev_out);
    check({tag, ".rem_hold"}, 32'(bus.rem), prev_rem);
    check({tag, ".V_hold"},   32'(bus.V),   prev_v);
    check({tag, ".Z_hold"},   32'(bus.Z),   prev_z);
  endtask

  // Issues a/b in the current cycle (cycle 0) and follows the operation up to
  // one cycle past done. If inject_cycle > 0, a spurious start with 1/1 is
  // driven in that cycle; mid-operation a/b are otherwise scrambled.
  task automatic run_op(input string tag, input int a, input int b, input int inject_cycle);
    int exp_q, exp_r, exp_v, exp_z, lat;
    ref_div(a, b, exp_q, exp_r, exp_v, exp_z);
    lat = (b == 0) ? 1 : W + 1;

    bus.start = 1'b1;
    bus.a     = W'(a);
    bus.b     = W'(b);
    for (int c = 1; c <= lat; c++) begin
      tick();
      if (c == inject_cycle) begin
        bus.start = 1'b1;
        bus.a     = W'(1);
        bus.b     = W'(1);
      end else begin
        bus.start = 1'b0;
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
      end
      check({tag, ".busy"}, 32'(bus.busy), 1);
      check({tag, ".done"}, 32'(bus.done), (c == lat) ? 1 : 0);
      if (c < lat) begin
        check_held(tag);
      end else begin
        check({tag, ".out"}, 32'(bus.out), exp_q);
        check({tag, ".rem"}, 32'(bus.rem), exp_r);
        check({tag, ".V"},   32'(bus.V),   exp_v);
        check({tag, ".Z"},   32'(bus.Z),   exp_z);
      end
    end
    bus.start = 1'b0;
    prev_out  = exp_q;
    prev_rem  = exp_r;
    prev_v    = exp_v;
    prev_z    = exp_z;
    tick();
    check({tag, ".idle_busy"}, 32'(bus.busy), 0);
    check({tag, ".idle_done"}, 32'(bus.done), 0);
    check_held({tag, ".idle"});
  endtask

  initial begin
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;

    // Reset state.
    tick();
    tick();
    check("rst.out",  32'(bus.out),  0);
    check("rst.rem",  32'(bus.rem),  0);
    check("rst.V",    32'(bus.V),    0);
    check("rst.Z",    32'(bus.Z),    0);
    check("rst.busy", 32'(bus.busy), 0);
    check("rst.done", 32'(bus.done), 0);
    rst_n = 1'b1;
    tick();
    check("post_rst.busy", 32'(bus.busy), 0);
    check("post_rst.done", 32'(bus.done), 0);

    // Directed operations.
    run_op("d13_4", 13, 4, 0);
    run_op("d3_7",  3,  7, 0);
    run_op("d15_1", 15, 1, 0);   // issued the cycle after the previous done
    run_op("d9_0",  9,  0, 0);
    run_op("d12_5", 12, 5, 2);   // start with 1/1 in cycle 2 must be ignored
    run_op("d0_5",  0,  5, 0);
    run_op("d15_15", 15, 15, 0);
    run_op("d0_0",  0,  0, 0);

    // Reset in the middle of an operation aborts it without a done pulse.
    bus.start = 1'b1;
    bus.a     = W'(14);
    bus.b     = W'(3);
    tick();                       // cycle 1
    bus.start = 1'b0;
    tick();                       // cycle 2
    tick();                       // cycle 3
    rst_n = 1'b0;
    #1;
    check("abort.out",  32'(bus.out),  0);
    check("abort.rem",  32'(bus.rem),  0);
    check("abort.V",    32'(bus.V),    0);
    check("abort.Z",    32'(bus.Z),    0);
    check("abort.busy", 32'(bus.busy), 0);
    check("abort.done", 32'(bus.done), 0);
    tick();
    tick();
    check("abort_hold.done", 32'(bus.done), 0);
    check("abort_hold.busy", 32'(bus.busy), 0);
    rst_n    = 1'b1;
    prev_out = 0;
    prev_rem = 0;
    prev_v   = 0;
    prev_z   = 0;
    tick();
    check("abort_idle.done", 32'(bus.done), 0);
    run_op("d14_3", 14, 3, 0);

    // Randomized back-to-back operations.
    for (int i = 0; i < 40; i++) begin
      int ra, rb;
      ra = int'($urandom_range(0, MASK));
      rb = int'($urandom_range(0, MASK));
      run_op($sformatf("rnd%0d_%0d_%0d", i, ra, rb), ra, rb, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
